// File: rtl/an_sec_decoder_seq.sv
// an_sec_decoder_seq: sequential single-error-correcting AN-code decoder.
// A received word W = A*N + e is divided by A to get a residue R. A search
// then looks for a single arithmetic error of +/-2^i that explains R. A second
// division of (W - Delta) by A recovers N.
// Optional feature: define AN_DEC_STATS_EN to get saturating corrected and
// uncorrectable counters on cnt_corr/cnt_uncorr. Otherwise they are tied to 0.
module an_sec_decoder_seq #(
    parameter int K  = 12,
    parameter int A  = 3349,
    parameter int CW = 2 * K
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [CW-1:0]         w_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [K-1:0]          n_out,
    output logic                  err_corr,
    output logic                  err_uncorr,
    output logic [$clog2(CW)-1:0] err_pos,
    output logic                  err_neg,
    output logic [15:0]           cnt_corr,
    output logic [15:0]           cnt_uncorr
);

    localparam int PW   = $clog2(CW);
    localparam int CNTW = $clog2(CW + 1);
    localparam logic [CW-1:0]   A_W     = CW'(A);
    localparam logic [CNTW-1:0] LAST    = CNTW'(CW - 1);
    localparam logic [CNTW-1:0] LAST_D2 = CNTW'(CW);

    typedef enum logic [2:0] {IDLE, DIV1, SRCH, DIV2, OUT} state_t;

    state_t          state_reg, state_next;
    logic [CNTW-1:0] cnt_reg;
    logic [CW-1:0]   w_reg;      // captured codeword, kept for the second division
    logic [CW-1:0]   dvd_reg;    // dividend shifting out, quotient shifting in
    logic [CW-1:0]   rem_reg;    // partial remainder, always < A
    logic [K-1:0]    q1_reg;     // first-pass quotient, used as fallback result
    logic [CW-1:0]   r_reg;      // residue W mod A
    logic [CW-1:0]   p_reg;      // 2^i mod A for the current search step
    logic            found_reg;
    logic [PW-1:0]   fpos_reg;
    logic            fneg_reg;
    logic            dneg_reg;   // W - Delta went negative

    logic [K-1:0]    n_reg;
    logic            corr_reg, uncorr_reg, neg_reg;
    logic [PW-1:0]   pos_reg;

    // One restoring-division step shared by both division phases.
    logic [CW:0]     trial;
    logic            trial_ge;
    logic [CW:0]     trial_sub;
    logic [CW-1:0]   rem_step;
    logic [CW-1:0]   dvd_step;

    // Search helpers: next power-of-two residue and the negative-error target.
    logic [CW:0]     p_dbl;
    logic [CW:0]     p_dbl_sub;
    logic [CW-1:0]   p_step;
    logic [CW-1:0]   p_neg;
    logic            hit_pos, hit_neg;

    // Corrected dividend for the second division, CW+1-bit two's complement.
    logic [CW:0]     pow;
    logic [CW:0]     diff;
    logic            q_high;

    // Divider step, search step and correction arithmetic.
    always_comb begin
        trial     = {rem_reg, dvd_reg[CW-1]};
        trial_ge  = (trial >= {1'b0, A_W});
        trial_sub = trial - {1'b0, A_W};
        rem_step  = trial_ge ? trial_sub[CW-1:0] : trial[CW-1:0];
        dvd_step  = {dvd_reg[CW-2:0], trial_ge};

        p_dbl     = {p_reg, 1'b0};
        p_dbl_sub = p_dbl - {1'b0, A_W};
        p_step    = (p_dbl >= {1'b0, A_W}) ? p_dbl_sub[CW-1:0] : p_dbl[CW-1:0];
        p_neg     = A_W - p_reg;
        hit_pos   = (r_reg == p_reg);
        hit_neg   = (r_reg == p_neg);

        pow       = {{CW{1'b0}}, 1'b1} << fpos_reg;
        if (!found_reg)
            diff = {1'b0, w_reg};
        else if (fneg_reg)
            diff = {1'b0, w_reg} + pow;
        else
            diff = {1'b0, w_reg} - pow;

        q_high    = ((dvd_step >> K) != '0);
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_reg <= IDLE;
        else
            state_reg <= state_next;
    end

    // Next-state logic. The phase counter decides when each phase ends.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (in_valid)           state_next = DIV1;
            DIV1: if (cnt_reg == LAST)    state_next = SRCH;
            SRCH: if (cnt_reg == LAST)    state_next = DIV2;
            DIV2: if (cnt_reg == LAST_D2) state_next = OUT;
            OUT:  if (out_ready)          state_next = IDLE;
            default:                      state_next = IDLE;
        endcase
    end

    assign in_ready  = (state_reg == IDLE);
    assign out_valid = (state_reg == OUT);

    // Datapath: capture, first division, error search, corrected division, result.
    // DIV2 spends its first cycle loading W - Delta and then CW division steps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg    <= '0;
            w_reg      <= '0;
            dvd_reg    <= '0;
            rem_reg    <= '0;
            q1_reg     <= '0;
            r_reg      <= '0;
            p_reg      <= '0;
            found_reg  <= 1'b0;
            fpos_reg   <= '0;
            fneg_reg   <= 1'b0;
            dneg_reg   <= 1'b0;
            n_reg      <= '0;
            corr_reg   <= 1'b0;
            uncorr_reg <= 1'b0;
            pos_reg    <= '0;
            neg_reg    <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        w_reg   <= w_in;
                        dvd_reg <= w_in;
                        rem_reg <= '0;
                        cnt_reg <= '0;
                    end
                end
                DIV1: begin
                    dvd_reg <= dvd_step;
                    rem_reg <= rem_step;
                    if (cnt_reg == LAST) begin
                        q1_reg    <= dvd_step[K-1:0];
                        r_reg     <= rem_step;
                        p_reg     <= {{(CW-1){1'b0}}, 1'b1};
                        found_reg <= 1'b0;
                        fpos_reg  <= '0;
                        fneg_reg  <= 1'b0;
                        cnt_reg   <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                SRCH: begin
                    // The first hit wins, so the lowest i is kept and +2^i beats -2^i.
                    if (!found_reg && (hit_pos || hit_neg)) begin
                        found_reg <= 1'b1;
                        fpos_reg  <= PW'(cnt_reg);
                        fneg_reg  <= !hit_pos;
                    end
                    p_reg   <= p_step;
                    cnt_reg <= (cnt_reg == LAST) ? '0 : cnt_reg + 1'b1;
                end
                DIV2: begin
                    if (cnt_reg == '0) begin
                        dneg_reg <= diff[CW];
                        dvd_reg  <= diff[CW-1:0];
                        rem_reg  <= '0;
                    end else begin
                        dvd_reg <= dvd_step;
                        rem_reg <= rem_step;
                    end
                    if (cnt_reg == LAST_D2) begin
                        if (dneg_reg || q_high) begin
                            n_reg      <= q1_reg;
                            corr_reg   <= 1'b0;
                            uncorr_reg <= 1'b1;
                            pos_reg    <= '0;
                            neg_reg    <= 1'b0;
                        end else begin
                            n_reg      <= dvd_step[K-1:0];
                            corr_reg   <= found_reg;
                            uncorr_reg <= (r_reg != '0) && !found_reg;
                            pos_reg    <= found_reg ? fpos_reg : '0;
                            neg_reg    <= found_reg && fneg_reg;
                        end
                        cnt_reg <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign n_out      = n_reg;
    assign err_corr   = corr_reg;
    assign err_uncorr = uncorr_reg;
    assign err_pos    = pos_reg;
    assign err_neg    = neg_reg;

`ifdef AN_DEC_STATS_EN
    logic [15:0] cnt_corr_reg, cnt_uncorr_reg;

    // Saturating error statistics, counted once per delivered result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_corr_reg   <= '0;
            cnt_uncorr_reg <= '0;
        end else if (state_reg == OUT && out_ready) begin
            if (corr_reg && cnt_corr_reg != 16'hFFFF)
                cnt_corr_reg <= cnt_corr_reg + 16'd1;
            if (uncorr_reg && cnt_uncorr_reg != 16'hFFFF)
                cnt_uncorr_reg <= cnt_uncorr_reg + 16'd1;
        end
    end

    assign cnt_corr   = cnt_corr_reg;
    assign cnt_uncorr = cnt_uncorr_reg;
`else
    assign cnt_corr   = '0;
    assign cnt_uncorr = '0;
`endif

endmodule

// File: tb/tb_an_sec_decoder_seq.sv
// Directed testbench for an_sec_decoder_seq (K=12, A=3349, CW=24).
module tb_an_sec_decoder_seq;

    localparam int K  = 12;
    localparam int A  = 3349;
    localparam int CW = 24;
    localparam int LAT = 3 * CW + 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [CW-1:0] w_in = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [K-1:0]  n_out;
    logic          err_corr, err_uncorr, err_neg;
    logic [4:0]    err_pos;
    logic [15:0]   cnt_corr, cnt_uncorr;

    int total = 0;
    int bad = 0;
    int exp_cc = 0;
    int exp_cu = 0;

    an_sec_decoder_seq #(.K(K), .A(A), .CW(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .w_in(w_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .n_out(n_out), .err_corr(err_corr), .err_uncorr(err_uncorr),
        .err_pos(err_pos), .err_neg(err_neg),
        .cnt_corr(cnt_corr), .cnt_uncorr(cnt_uncorr)
    );

    always #5 clk = ~clk;

    // Offer one codeword and count cycles from the accept edge to out_valid (-1 on timeout).
    task automatic run_word(input logic [CW-1:0] w, output int lat);
        int guard = 0;
        @(negedge clk);
        while (!in_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        in_valid = 1'b1;
        w_in = w;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (!out_valid) lat = -1;
    endtask

    // Complete the output handshake and account the expected statistics.
    task automatic take_result(input logic ec, input logic eu);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
`ifdef AN_DEC_STATS_EN
        if (ec) exp_cc++;
        if (eu) exp_cu++;
`endif
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_hs: in_ready=%b out_valid=%b want 1 0", in_ready, out_valid);
        end
        total++;
        if (n_out !== 12'd0 || err_corr !== 1'b0 || err_uncorr !== 1'b0 || err_pos !== 5'd0 || err_neg !== 1'b0) begin
            bad++;
            $display("FAIL reset_out: n=%0d c=%b u=%b pos=%0d neg=%b want all 0", n_out, err_corr, err_uncorr, err_pos, err_neg);
        end
        total++;
        if (cnt_corr !== 16'd0 || cnt_uncorr !== 16'd0) begin
            bad++;
            $display("FAIL reset_cnt: cc=%0d cu=%0d want 0 0", cnt_corr, cnt_uncorr);
        end
        @(negedge clk);
        rst_n = 1'b1;
        $display("reset: in_ready=%b out_valid=%b n_out=%0d", in_ready, out_valid, n_out);
    endtask

    task automatic test_clean();
        logic [CW-1:0] ws [3];
        logic [K-1:0]  ns [3];
        int lat;
        ws = '{24'd16745, 24'd0, 24'd13714155};
        ns = '{12'd5, 12'd0, 12'd4095};
        for (int t = 0; t < 3; t++) begin
            run_word(ws[t], lat);
            total++;
            if (lat !== LAT) begin
                bad++;
                $display("FAIL clean_lat[%0d]: got %0d want %0d", t, lat, LAT);
            end
            total++;
            if (n_out !== ns[t] || err_corr !== 1'b0 || err_uncorr !== 1'b0 || err_pos !== 5'd0 || err_neg !== 1'b0) begin
                bad++;
                $display("FAIL clean_out[%0d]: n=%0d c=%b u=%b pos=%0d neg=%b want n=%0d clean", t, n_out, err_corr, err_uncorr, err_pos, err_neg, ns[t]);
            end
            $display("clean: W=%0d lat=%0d n_out=%0d c=%b u=%b", ws[t], lat, n_out, err_corr, err_uncorr);
            take_result(1'b0, 1'b0);
        end
    endtask

    task automatic test_correct();
        logic [CW-1:0] ws [3];
        logic [4:0]    ps [3];
        logic          gs [3];
        int lat;
        ws = '{24'd16746, 24'd12649, 24'd16744};
        ps = '{5'd0, 5'd12, 5'd0};
        gs = '{1'b0, 1'b1, 1'b1};
        for (int t = 0; t < 3; t++) begin
            run_word(ws[t], lat);
            total++;
            if (lat !== LAT) begin
                bad++;
                $display("FAIL corr_lat[%0d]: got %0d want %0d", t, lat, LAT);
            end
            total++;
            if (n_out !== 12'd5 || err_corr !== 1'b1 || err_uncorr !== 1'b0 || err_pos !== ps[t] || err_neg !== gs[t]) begin
                bad++;
                $display("FAIL corr_out[%0d]: n=%0d c=%b u=%b pos=%0d neg=%b want n=5 c=1 u=0 pos=%0d neg=%b", t, n_out, err_corr, err_uncorr, err_pos, err_neg, ps[t], gs[t]);
            end
            $display("correct: W=%0d n_out=%0d pos=%0d neg=%b", ws[t], n_out, err_pos, err_neg);
            take_result(1'b1, 1'b0);
        end
        total++;
        if (cnt_corr !== 16'(exp_cc)) begin
            bad++;
            $display("FAIL corr_cnt: got %0d want %0d", cnt_corr, exp_cc);
        end
    endtask

    task automatic test_uncorrectable();
        // 16748: residue 3 matches no +/-2^i; 747: matches +2^12 but W-Delta < 0;
        // 4096*A: clean residue but quotient out of range.
        logic [CW-1:0] ws [3];
        logic [K-1:0]  ns [3];
        int lat;
        ws = '{24'd16748, 24'd747, 24'd13717504};
        ns = '{12'd5, 12'd0, 12'd0};
        for (int t = 0; t < 3; t++) begin
            run_word(ws[t], lat);
            total++;
            if (lat !== LAT) begin
                bad++;
                $display("FAIL unc_lat[%0d]: got %0d want %0d", t, lat, LAT);
            end
            total++;
            if (n_out !== ns[t] || err_corr !== 1'b0 || err_uncorr !== 1'b1 || err_pos !== 5'd0 || err_neg !== 1'b0) begin
                bad++;
                $display("FAIL unc_out[%0d]: n=%0d c=%b u=%b pos=%0d neg=%b want n=%0d c=0 u=1", t, n_out, err_corr, err_uncorr, err_pos, err_neg, ns[t]);
            end
            $display("uncorrectable: W=%0d n_out=%0d u=%b", ws[t], n_out, err_uncorr);
            take_result(1'b0, 1'b1);
        end
        total++;
        if (cnt_uncorr !== 16'(exp_cu)) begin
            bad++;
            $display("FAIL unc_cnt: got %0d want %0d", cnt_uncorr, exp_cu);
        end
    endtask

    task automatic test_backpressure();
        int lat;
        int stray = 0;
        int unstable = 0;
        run_word(24'd16746, lat);
        total++;
        if (lat !== LAT) begin
            bad++;
            $display("FAIL bp_lat: got %0d want %0d", lat, LAT);
        end
        in_valid = 1'b1;
        w_in = 24'd16745;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || n_out !== 12'd5 || err_corr !== 1'b1 || err_pos !== 5'd0 || err_neg !== 1'b0)
                unstable++;
        end
        total++;
        if (unstable != 0) begin
            bad++;
            $display("FAIL bp_hold: %0d unstable cycles want 0", unstable);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        in_valid = 1'b0;
`ifdef AN_DEC_STATS_EN
        exp_cc++;
`endif
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL bp_release: out_valid=%b in_ready=%b want 0 1", out_valid, in_ready);
        end
        for (int c = 0; c < LAT + 10; c++) begin
            @(posedge clk);
            #1;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) stray++;
        end
        total++;
        if (stray != 0) begin
            bad++;
            $display("FAIL bp_idle: %0d non-idle cycles after release want 0", stray);
        end
        total++;
        if (cnt_corr !== 16'(exp_cc)) begin
            bad++;
            $display("FAIL bp_cnt: got %0d want %0d", cnt_corr, exp_cc);
        end
        $display("backpressure: held 10 cycles, unstable=%0d stray=%0d", unstable, stray);
    endtask

    task automatic test_reset_midop();
        int lat;
        int stray = 0;
        @(negedge clk);
        in_valid = 1'b1;
        w_in = 24'd16746;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (30) @(posedge clk);   // well inside the search phase
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || n_out !== 12'd0 || err_corr !== 1'b0 || err_uncorr !== 1'b0 || cnt_corr !== 16'd0 || cnt_uncorr !== 16'd0) begin
            bad++;
            $display("FAIL midop_rst: rdy=%b ov=%b n=%0d c=%b u=%b cc=%0d cu=%0d want reset values", in_ready, out_valid, n_out, err_corr, err_uncorr, cnt_corr, cnt_uncorr);
        end
        exp_cc = 0;
        exp_cu = 0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < LAT + 10; c++) begin
            @(posedge clk);
            #1;
            if (out_valid !== 1'b0) stray++;
        end
        total++;
        if (stray != 0) begin
            bad++;
            $display("FAIL midop_discard: out_valid seen %0d cycles want 0", stray);
        end
        run_word(24'd16745, lat);
        total++;
        if (lat !== LAT || n_out !== 12'd5 || err_corr !== 1'b0 || err_uncorr !== 1'b0) begin
            bad++;
            $display("FAIL midop_after: lat=%0d n=%0d c=%b u=%b want lat=%0d n=5 clean", lat, n_out, err_corr, err_uncorr, LAT);
        end
        $display("reset_midop: discarded, next W=16745 lat=%0d n_out=%0d", lat, n_out);
        take_result(1'b0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_clean();
        test_correct();
        test_uncorrectable();
        test_backpressure();
        test_reset_midop();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
